// File: rtl/frame_scheduler.sv
// -----------------------------------------------------------------------------
// frame_scheduler
//
// Walks the raster of one video frame and hands each (x, y) coordinate to the
// pixel packer over a valid/ready handshake.  Geometry is captured into shadow
// registers when a frame starts, so the register file may be rewritten at any
// time without tearing the frame that is in flight.
//
// Ports
//   out_stream_aclk   clock
//   axi_resetn        synchronous reset, active HIGH despite its name
//   cfg_width         pixels per line (0 behaves as 1)
//   cfg_height        lines per frame (0 behaves as 1)
//   cfg_enable        level run request
//   cfg_oneshot       1: one frame per cfg_start pulse, 0: continuous
//   cfg_start         one-shot trigger pulse
//   pix_x / pix_y     current coordinate
//   pix_first         coordinate is (0,0) of the frame
//   pix_eol           coordinate is the last pixel of its line
//   pix_valid         coordinate is offered
//   pix_ready         datapath accepts the coordinate
//   busy              a frame is in progress
//   frame_done        one-cycle pulse after the last pixel is accepted
//   frame_count       completed frames, wrapping
// -----------------------------------------------------------------------------
module frame_scheduler #(
    parameter int X_BITS    = 10,
    parameter int Y_BITS    = 9,
    parameter int FCNT_BITS = 16
) (
    input  logic                 out_stream_aclk,
    input  logic                 axi_resetn,
    input  logic [X_BITS-1:0]    cfg_width,
    input  logic [Y_BITS-1:0]    cfg_height,
    input  logic                 cfg_enable,
    input  logic                 cfg_oneshot,
    input  logic                 cfg_start,
    output logic [X_BITS-1:0]    pix_x,
    output logic [Y_BITS-1:0]    pix_y,
    output logic                 pix_first,
    output logic                 pix_eol,
    output logic                 pix_valid,
    input  logic                 pix_ready,
    output logic                 busy,
    output logic                 frame_done,
    output logic [FCNT_BITS-1:0] frame_count
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                 state_q, state_d;
    logic [X_BITS-1:0]      shadow_w_q, shadow_w_d;
    logic [Y_BITS-1:0]      shadow_h_q, shadow_h_d;
    logic [X_BITS-1:0]      x_d;
    logic [Y_BITS-1:0]      y_d;
    logic                   valid_d;
    logic                   done_d;
    logic [FCNT_BITS-1:0]   count_d;

    logic [X_BITS-1:0]      cfg_w_clamped;
    logic [Y_BITS-1:0]      cfg_h_clamped;
    logic                   accept;
    logic                   last_x;
    logic                   last_y;
    logic                   cont_go;
    logic                   start_go;

    // A zero-sized geometry is promoted to 1 so the counters always have a
    // valid terminal value and shadow-1 never underflows.
    assign cfg_w_clamped = (cfg_width  == '0) ? X_BITS'(1) : cfg_width;
    assign cfg_h_clamped = (cfg_height == '0) ? Y_BITS'(1) : cfg_height;

    assign accept   = pix_valid && pix_ready;
    assign last_x   = (pix_x == shadow_w_q - X_BITS'(1));
    assign last_y   = (pix_y == shadow_h_q - Y_BITS'(1));
    assign cont_go  = cfg_enable && !cfg_oneshot;
    assign start_go = cont_go || (cfg_enable && cfg_oneshot && cfg_start);

    // State and datapath registers; reset aborts any frame in flight.
    always_ff @(posedge out_stream_aclk) begin
        if (axi_resetn) begin
            state_q     <= IDLE;
            pix_x       <= '0;
            pix_y       <= '0;
            pix_valid   <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
            shadow_w_q  <= X_BITS'(1);
            shadow_h_q  <= Y_BITS'(1);
        end else begin
            state_q     <= state_d;
            pix_x       <= x_d;
            pix_y       <= y_d;
            pix_valid   <= valid_d;
            frame_done  <= done_d;
            frame_count <= count_d;
            shadow_w_q  <= shadow_w_d;
            shadow_h_q  <= shadow_h_d;
        end
    end

    // Next-state and coordinate stepping.  At end of frame, continuous mode
    // reloads the shadows and restarts at (0,0) on the same edge so there is
    // no idle bubble between frames; start pulses seen in RUN are dropped.
    always_comb begin
        state_d    = state_q;
        x_d        = pix_x;
        y_d        = pix_y;
        shadow_w_d = shadow_w_q;
        shadow_h_d = shadow_h_q;
        done_d     = 1'b0;
        count_d    = frame_count;

        case (state_q)
            IDLE: begin
                if (start_go) begin
                    state_d    = RUN;
                    x_d        = '0;
                    y_d        = '0;
                    shadow_w_d = cfg_w_clamped;
                    shadow_h_d = cfg_h_clamped;
                end
            end
            RUN: begin
                if (accept) begin
                    if (!last_x) begin
                        x_d = pix_x + X_BITS'(1);
                    end else begin
                        x_d = '0;
                        if (!last_y) begin
                            y_d = pix_y + Y_BITS'(1);
                        end else begin
                            y_d     = '0;
                            done_d  = 1'b1;
                            count_d = frame_count + FCNT_BITS'(1);
                            if (cont_go) begin
                                shadow_w_d = cfg_w_clamped;
                                shadow_h_d = cfg_h_clamped;
                            end else begin
                                state_d = IDLE;
                            end
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        valid_d = (state_d == RUN);
    end

    // Combinational status derived from the registered coordinate and state.
    always_comb begin
        busy      = (state_q == RUN);
        pix_first = (pix_x == '0) && (pix_y == '0);
        pix_eol   = last_x;
    end

endmodule

// File: tb/tb_frame_scheduler.sv
// -----------------------------------------------------------------------------
// tb_frame_scheduler
//
// Self-checking bench for frame_scheduler: a short directed vector table,
// scenario sequences for the multi-cycle corner cases, a frame counter wrap,
// and a randomized run, all compared against a behavioural model that tracks
// a linear pixel index per frame.
// -----------------------------------------------------------------------------
module tb_frame_scheduler;

    localparam int X_BITS    = 10;
    localparam int Y_BITS    = 9;
    localparam int FCNT_BITS = 16;

    logic                 clk;
    logic                 rst;
    logic [X_BITS-1:0]    cfg_width;
    logic [Y_BITS-1:0]    cfg_height;
    logic                 cfg_enable;
    logic                 cfg_oneshot;
    logic                 cfg_start;
    logic [X_BITS-1:0]    pix_x;
    logic [Y_BITS-1:0]    pix_y;
    logic                 pix_first;
    logic                 pix_eol;
    logic                 pix_valid;
    logic                 pix_ready;
    logic                 busy;
    logic                 frame_done;
    logic [FCNT_BITS-1:0] frame_count;

    int checkCount = 0;
    int passCount  = 0;
    bit doCheck    = 1'b1;

    // Behavioural model: frame progress as a linear pixel index.
    bit m_run;
    int m_idx;
    int m_w;
    int m_h;
    int m_count;
    bit m_done;

    frame_scheduler #(
        .X_BITS   (X_BITS),
        .Y_BITS   (Y_BITS),
        .FCNT_BITS(FCNT_BITS)
    ) dut (
        .out_stream_aclk(clk),
        .axi_resetn     (rst),
        .cfg_width      (cfg_width),
        .cfg_height     (cfg_height),
        .cfg_enable     (cfg_enable),
        .cfg_oneshot    (cfg_oneshot),
        .cfg_start      (cfg_start),
        .pix_x          (pix_x),
        .pix_y          (pix_y),
        .pix_first      (pix_first),
        .pix_eol        (pix_eol),
        .pix_valid      (pix_valid),
        .pix_ready      (pix_ready),
        .busy           (busy),
        .frame_done     (frame_done),
        .frame_count    (frame_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        int w;
        int h;
        bit en;
        bit os;
        bit start;
        bit ready;
        bit valid;
        int x;
        int y;
        bit first;
        bit eol;
        bit done;
        int count;
    } vec_t;

    vec_t vecs[12];

    task automatic checkField(input string name, input int act, input int exp);
        checkCount++;
        if (act == exp) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Model update for one clock edge using the inputs currently driven.
    task automatic modelEdge();
        bit accept;
        bit cont;
        bit go;
        accept = m_run && pix_ready;
        cont   = cfg_enable && !cfg_oneshot;
        go     = cont || (cfg_enable && cfg_oneshot && cfg_start);
        m_done = 1'b0;
        if (rst) begin
            m_run   = 1'b0;
            m_idx   = 0;
            m_w     = 1;
            m_h     = 1;
            m_count = 0;
        end else if (!m_run) begin
            if (go) begin
                m_run = 1'b1;
                m_idx = 0;
                m_w   = (cfg_width  == 0) ? 1 : int'(cfg_width);
                m_h   = (cfg_height == 0) ? 1 : int'(cfg_height);
            end
        end else if (accept) begin
            m_idx++;
            if (m_idx == m_w * m_h) begin
                m_done  = 1'b1;
                m_count = (m_count + 1) % (1 << FCNT_BITS);
                m_idx   = 0;
                if (cont) begin
                    m_w = (cfg_width  == 0) ? 1 : int'(cfg_width);
                    m_h = (cfg_height == 0) ? 1 : int'(cfg_height);
                end else begin
                    m_run = 1'b0;
                end
            end
        end
    endtask

    task automatic checkOutput();
        int ex;
        int ey;
        checkField("pix_valid", int'(pix_valid), int'(m_run));
        checkField("busy", int'(busy), int'(m_run));
        checkField("frame_done", int'(frame_done), int'(m_done));
        checkField("frame_count", int'(frame_count), m_count);
        if (m_run) begin
            ex = m_idx % m_w;
            ey = m_idx / m_w;
            checkField("pix_x", int'(pix_x), ex);
            checkField("pix_y", int'(pix_y), ey);
            checkField("pix_first", int'(pix_first), int'(m_idx == 0));
            checkField("pix_eol", int'(pix_eol), int'(ex == m_w - 1));
        end
    endtask

    // One clock: model the edge, let the DUT take it, compare after the edge.
    task automatic applyStimulus();
        modelEdge();
        @(posedge clk);
        #1;
        if (doCheck) checkOutput();
    endtask

    task automatic setCfg(input int w, input int h, input bit en, input bit os);
        cfg_width   = X_BITS'(w);
        cfg_height  = Y_BITS'(h);
        cfg_enable  = en;
        cfg_oneshot = os;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus();
        rst = 1'b0;
    endtask

    initial begin
        int frames;
        int edgesToDone;

        rst         = 1'b1;
        cfg_width   = '0;
        cfg_height  = '0;
        cfg_enable  = 1'b0;
        cfg_oneshot = 1'b0;
        cfg_start   = 1'b0;
        pix_ready   = 1'b0;
        m_run = 0; m_idx = 0; m_w = 1; m_h = 1; m_count = 0; m_done = 0;

        // Directed vectors: {rst,w,h,en,os,start,ready, valid,x,y,first,eol,done,count}
        vecs[0]  = '{1, 2, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0};
        vecs[1]  = '{0, 2, 1, 1, 0, 0, 1,  1, 0, 0, 1, 0, 0, 0};
        vecs[2]  = '{0, 2, 1, 1, 0, 0, 1,  1, 1, 0, 0, 1, 0, 0};
        vecs[3]  = '{0, 2, 1, 1, 0, 0, 1,  1, 0, 0, 1, 0, 1, 1};
        vecs[4]  = '{0, 2, 1, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 1};
        vecs[5]  = '{0, 2, 1, 0, 0, 0, 1,  1, 1, 0, 0, 1, 0, 1};
        vecs[6]  = '{0, 2, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 1, 2};
        vecs[7]  = '{0, 2, 1, 0, 0, 0, 1,  0, 0, 0, 0, 0, 0, 2};
        vecs[8]  = '{0, 2, 1, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 2};
        vecs[9]  = '{0, 0, 0, 1, 1, 1, 1,  1, 0, 0, 1, 1, 0, 2};
        vecs[10] = '{0, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 1, 3};
        vecs[11] = '{1, 0, 0, 1, 1, 0, 1,  0, 0, 0, 0, 0, 0, 0};

        for (int i = 0; i < 12; i++) begin
            rst       = vecs[i].rst;
            setCfg(vecs[i].w, vecs[i].h, vecs[i].en, vecs[i].os);
            cfg_start = vecs[i].start;
            pix_ready = vecs[i].ready;
            @(posedge clk);
            #1;
            checkField($sformatf("vec%0d.valid", i), int'(pix_valid), int'(vecs[i].valid));
            checkField($sformatf("vec%0d.done", i), int'(frame_done), int'(vecs[i].done));
            checkField($sformatf("vec%0d.count", i), int'(frame_count), vecs[i].count);
            if (vecs[i].valid) begin
                checkField($sformatf("vec%0d.x", i), int'(pix_x), vecs[i].x);
                checkField($sformatf("vec%0d.y", i), int'(pix_y), vecs[i].y);
                checkField($sformatf("vec%0d.first", i), int'(pix_first), int'(vecs[i].first));
                checkField($sformatf("vec%0d.eol", i), int'(pix_eol), int'(vecs[i].eol));
            end
        end
        cfg_start = 1'b0;

        // Continuous 4x3: frame_done must appear on the 13th edge after enable.
        setCfg(4, 3, 1'b0, 1'b0);
        pix_ready = 1'b1;
        doReset();
        cfg_enable  = 1'b1;
        edgesToDone = 0;
        for (int i = 1; i <= 30; i++) begin
            applyStimulus();
            if (frame_done && edgesToDone == 0) edgesToDone = i;
        end
        checkField("first_done_edge", edgesToDone, 13);

        // Back-pressure on 3x2 with ready pattern 1,0,0,1.
        setCfg(3, 2, 1'b0, 1'b0);
        doReset();
        cfg_enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            pix_ready = (i % 4 == 0) || (i % 4 == 3);
            applyStimulus();
        end

        // One-shot 2x2 with a second start while running.
        pix_ready = 1'b1;
        setCfg(2, 2, 1'b0, 1'b1);
        doReset();
        cfg_enable = 1'b1;
        applyStimulus();
        cfg_start = 1'b1;
        applyStimulus();
        cfg_start = 1'b0;
        applyStimulus();
        cfg_start = 1'b1;
        applyStimulus();
        cfg_start = 1'b0;
        for (int i = 0; i < 6; i++) applyStimulus();
        checkField("oneshot_count", int'(frame_count), 1);
        checkField("oneshot_busy", int'(busy), 0);

        // Width 4->2 written at pixel (1,1) of a 4x3 continuous frame.
        setCfg(4, 3, 1'b1, 1'b0);
        doReset();
        applyStimulus();
        while (m_idx != 5) applyStimulus();
        cfg_width = X_BITS'(2);
        for (int i = 0; i < 12; i++) applyStimulus();

        // Disable at pixel (2,1): frame finishes, one frame_done, then idle.
        setCfg(4, 3, 1'b1, 1'b0);
        doReset();
        applyStimulus();
        while (m_idx != 6) applyStimulus();
        cfg_enable = 1'b0;
        frames = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus();
            if (frame_done) frames++;
        end
        checkField("disable_done_pulses", frames, 1);

        // Reset at pixel (1,1), then restart with 0x0 giving 1x1 frames.
        setCfg(4, 3, 1'b1, 1'b0);
        doReset();
        applyStimulus();
        while (m_idx != 5) applyStimulus();
        doReset();
        setCfg(0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) applyStimulus();

        // frame_count wrap with 1x1 continuous frames.
        doReset();
        doCheck = 1'b0;
        for (int i = 0; i < 65534; i++) applyStimulus();
        doCheck = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus();

        // Randomized traffic.
        doReset();
        for (int i = 0; i < 3000; i++) begin
            pix_ready = ($urandom_range(0, 3) != 0);
            cfg_start = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 19) == 0) cfg_width  = X_BITS'($urandom_range(0, 5));
            if ($urandom_range(0, 19) == 0) cfg_height = Y_BITS'($urandom_range(0, 4));
            if ($urandom_range(0, 29) == 0) cfg_enable  = ~cfg_enable;
            if ($urandom_range(0, 39) == 0) cfg_oneshot = ~cfg_oneshot;
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus();
        end
        rst = 1'b0;

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
